// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator for parallel RGB LCD/VGA panels.
//                Horizontal/vertical counters in the pixel-clock domain with
//                registered sync, data-enable, coordinate and strobe outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int HACTIVE   = 480,
  parameter int HFP       = 2,
  parameter int HSYNC     = 41,
  parameter int HBP       = 2,
  parameter int VACTIVE   = 272,
  parameter int VFP       = 4,
  parameter int VSYNC     = 10,
  parameter int VBP       = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int HTOTAL    = HACTIVE + HFP + HSYNC + HBP,
  parameter int VTOTAL    = VACTIVE + VFP + VSYNC + VBP,
  parameter int XW        = $clog2(HTOTAL),
  parameter int YW        = $clog2(VTOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          restart_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // Window boundaries, sized to the counter widths so every compare is exact.
  localparam logic [XW-1:0] H_ACT_END  = XW'(HACTIVE);
  localparam logic [XW-1:0] H_SYNC_BEG = XW'(HACTIVE + HFP);
  localparam logic [XW-1:0] H_SYNC_END = XW'(HACTIVE + HFP + HSYNC);
  localparam logic [XW-1:0] H_LAST     = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END  = YW'(VACTIVE);
  localparam logic [YW-1:0] V_SYNC_BEG = YW'(VACTIVE + VFP);
  localparam logic [YW-1:0] V_SYNC_END = YW'(VACTIVE + VFP + VSYNC);
  localparam logic [YW-1:0] V_LAST     = YW'(VTOTAL - 1);

  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic [XW-1:0] hc_next;
  logic [YW-1:0] vc_next;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          in_active;

  // Next-count logic with explicit compare-and-wrap; the line counter only
  // advances on the last pixel of a line.
  always_comb begin
    hc_next = hc + XW'(1);
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = '0;
      if (vc == V_LAST) begin
        vc_next = '0;
      end else begin
        vc_next = vc + YW'(1);
      end
    end
  end

  // Decode of the current counter position into sync/active flags.
  always_comb begin
    h_in_sync = (hc >= H_SYNC_BEG) && (hc < H_SYNC_END);
    v_in_sync = (vc >= V_SYNC_BEG) && (vc < V_SYNC_END);
    in_active = (hc < H_ACT_END) && (vc < V_ACT_END);
  end

  // Counters and registered outputs; restart wins over enable, and strobes
  // drop to zero on stalled cycles so they never repeat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc            <= '0;
      vc            <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (restart_i) begin
      hc            <= '0;
      vc            <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (en_i) begin
      hc            <= hc_next;
      vc            <= vc_next;
      hsync_o       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      de_o          <= in_active;
      x_o           <= hc;
      y_o           <= vc;
      line_start_o  <= (hc == '0);
      frame_start_o <= (hc == '0) && (vc == '0);
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen with small raster
//                parameters (8 x 6 total) and a scoreboard of expected outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int HACTIVE = 4;
  localparam int HFP     = 1;
  localparam int HSYNC   = 2;
  localparam int HBP     = 1;
  localparam int VACTIVE = 3;
  localparam int VFP     = 1;
  localparam int VSYNC   = 1;
  localparam int VBP     = 1;
  localparam int HTOTAL  = 8;
  localparam int VTOTAL  = 6;
  localparam int XW      = 3;
  localparam int YW      = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic          hsync, vsync, de, line_start, frame_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ls;
    logic          fs;
  } exp_t;

  exp_t sb_q[$];
  exp_t prev;
  int   mhc = 0;
  int   mvc = 0;
  int   checks = 0;
  int   errors = 0;

  video_timing_gen #(
    .HACTIVE(HACTIVE), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VACTIVE(VACTIVE), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .restart_i    (restart),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .de_o         (de),
    .x_o          (x),
    .y_o          (y),
    .line_start_o (line_start),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference decode written from the panel layout: active x<4,y<3;
  // hsync low at x=5,6; vsync low on line 4 only.
  function automatic exp_t decode(input int h, input int v);
    exp_t e;
    e.de = (h < 4) && (v < 3);
    e.hs = (h == 5 || h == 6) ? 1'b0 : 1'b1;
    e.vs = (v == 4) ? 1'b0 : 1'b1;
    e.x  = XW'(h);
    e.y  = YW'(v);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t reset_val();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".hsync"}, 32'(hsync), 1);
    check({tag, ".vsync"}, 32'(vsync), 1);
    check({tag, ".de"}, 32'(de), 0);
    check({tag, ".x"}, 32'(x), 0);
    check({tag, ".y"}, 32'(y), 0);
    check({tag, ".ls"}, 32'(line_start), 0);
    check({tag, ".fs"}, 32'(frame_start), 0);
  endtask

  // Drive one cycle, push the expected post-edge outputs, then compare.
  task automatic step(input logic e, input logic r);
    exp_t ex;
    exp_t got;
    en      = e;
    restart = r;
    if (r) begin
      ex  = reset_val();
      mhc = 0;
      mvc = 0;
    end else if (e) begin
      ex = decode(mhc, mvc);
      if (mhc == HTOTAL - 1) begin
        mhc = 0;
        mvc = (mvc == VTOTAL - 1) ? 0 : mvc + 1;
      end else begin
        mhc = mhc + 1;
      end
    end else begin
      ex    = prev;
      ex.ls = 1'b0;
      ex.fs = 1'b0;
    end
    prev = ex;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb.hsync", 32'(hsync), 32'(got.hs));
    check("sb.vsync", 32'(vsync), 32'(got.vs));
    check("sb.de", 32'(de), 32'(got.de));
    check("sb.x", 32'(x), 32'(got.x));
    check("sb.y", 32'(y), 32'(got.y));
    check("sb.line_start", 32'(line_start), 32'(got.ls));
    check("sb.frame_start", 32'(frame_start), 32'(got.fs));
    en      = 1'b0;
    restart = 1'b0;
  endtask

  initial begin
    int n_de, n_hs, n_vs, n_ls, n_fs, len;
    bit found;
    prev = reset_val();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Scenario 1 + 2: steady enable over one full frame
    step(1'b1, 1'b0);
    check("s1.first_x", 32'(x), 0);
    check("s1.first_y", 32'(y), 0);
    check("s1.first_de", 32'(de), 1);
    check("s1.first_fs", 32'(frame_start), 1);
    n_de = (de ? 1 : 0); n_hs = (!hsync ? 1 : 0); n_vs = (!vsync ? 1 : 0);
    n_ls = (line_start ? 1 : 0); n_fs = (frame_start ? 1 : 0);
    for (int i = 1; i < HTOTAL * VTOTAL; i++) begin
      step(1'b1, 1'b0);
      n_de += (de ? 1 : 0);
      n_hs += (!hsync ? 1 : 0);
      n_vs += (!vsync ? 1 : 0);
      n_ls += (line_start ? 1 : 0);
      n_fs += (frame_start ? 1 : 0);
    end
    check("s1.de_count", 32'(n_de), 12);
    check("s1.hsync_low_count", 32'(n_hs), 12);
    check("s1.vsync_low_count", 32'(n_vs), 8);
    check("s2.line_starts", 32'(n_ls), 6);
    check("s2.frame_starts", 32'(n_fs), 1);
    step(1'b1, 1'b0);
    check("s2.wrap_x", 32'(x), 0);
    check("s2.wrap_y", 32'(y), 0);
    check("s2.wrap_fs", 32'(frame_start), 1);

    // Scenario 3: stall at x=2, frame length in enabled cycles stays 48
    len = 1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b0);
      if (frame_start) begin
        found = 1'b1;
      end else begin
        len++;
      end
      if (x == 2 && y == 0 && !found) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 1'b0);
          check("s3.hold_x", 32'(x), 2);
          check("s3.hold_ls", 32'(line_start), 0);
        end
        step(1'b1, 1'b0);
        len++;
        check("s3.resume_x", 32'(x), 3);
      end
    end
    check("s3.found_frame", 32'(found), 1);
    check("s3.frame_len", 32'(len), 48);

    // Stall right on a strobe: it must not repeat
    step(1'b0, 1'b0);
    check("s3.fs_not_repeated", 32'(frame_start), 0);

    // Scenario 4: restart at x=6,y=4 (inside both sync windows)
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1'b1, 1'b0);
      if (x == 6 && y == 4) found = 1'b1;
    end
    check("s4.reached_6_4", 32'(found), 1);
    check("s4.in_hsync", 32'(hsync), 0);
    check("s4.in_vsync", 32'(vsync), 0);
    step(1'b1, 1'b1);
    check_reset_outputs("s4.restart");
    step(1'b1, 1'b0);
    check("s4.after_fs", 32'(frame_start), 1);
    check("s4.after_de", 32'(de), 1);
    // Restart while disabled still resyncs
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_reset_outputs("s4.restart_no_en");
    step(1'b1, 1'b0);
    check("s4.fs_after_dis_restart", 32'(frame_start), 1);

    // Scenario 5: asynchronous reset between edges
    repeat (13) step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5.async");
    mhc = 0;
    mvc = 0;
    prev = reset_val();
    @(posedge clk);
    #1;
    check_reset_outputs("s5.held");
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    check("s5.recover_fs", 32'(frame_start), 1);
    check("s5.recover_de", 32'(de), 1);
    repeat (HTOTAL * VTOTAL) step(1'b1, 1'b0);
    check("s5.recover_wrap_fs", 32'(frame_start), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
